pixbuf_run_writer: RTL and testbench

//   Write-side companion of the pixel buffer.

---
 rtl/pixbuf_run_writer.sv | 131 +++++++++++++
 tb/tb_pixbuf_run_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pixbuf_run_writer.sv
// Expands (color, length) pixel runs into one pixbuf write per clock, filling
// a single row from address 0 up to ROW_LEN-1 each time row_start pulses.
module pixbuf_run_writer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10,
  parameter int ROW_LEN = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              row_start,
  input  logic              run_valid,
  output logic              run_ready,
  input  logic [DATA_W-1:0] run_color,
  input  logic [LEN_W-1:0]  run_len,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              row_done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_RUN, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_LEN - 1);
  localparam logic [LEN_W-1:0]  ONE       = LEN_W'(1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [LEN_W-1:0]    remaining, remaining_n;
  logic [DATA_W-1:0]   color, color_n;
  logic                overflow_n;
  logic                wr_n, run_ready_n, busy_n, row_done_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [DATA_W-1:0]   wr_data_n;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    color_n     = color;
    overflow_n  = overflow;
    wr_n        = 1'b1;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    run_ready_n = 1'b0;
    busy_n      = 1'b0;
    row_done_n  = 1'b0;

    // row_start restarts the row from any state; an in-flight run is dropped
    if (row_start) begin
      state_n    = WAIT_RUN;
      addr_n     = '0;
      overflow_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        WAIT_RUN: begin
          if (run_valid && run_ready && run_len != '0) begin
            state_n     = WRITE;
            color_n     = run_color;
            remaining_n = run_len;
          end
        end
        WRITE: begin
          if (addr == LAST_ADDR) begin
            state_n = DONE;
            if (remaining > ONE) overflow_n = 1'b1;
          end else if (remaining == ONE) begin
            state_n = WAIT_RUN;
            addr_n  = addr + 1'b1;
          end else begin
            addr_n      = addr + 1'b1;
            remaining_n = remaining - 1'b1;
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end

    // Outputs are registered, so they describe the state being entered
    unique case (state_n)
      WAIT_RUN: begin
        run_ready_n = 1'b1;
        busy_n      = 1'b1;
      end
      WRITE: begin
        wr_n      = 1'b0;
        wr_addr_n = addr_n;
        wr_data_n = color_n;
        busy_n    = 1'b1;
      end
      DONE:    row_done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      color     <= '0;
      overflow  <= 1'b0;
      wr        <= 1'b1;
      wr_addr   <= '0;
      wr_data   <= '0;
      run_ready <= 1'b0;
      busy      <= 1'b0;
      row_done  <= 1'b0;
    end else begin
      addr      <= addr_n;
      remaining <= remaining_n;
      color     <= color_n;
      overflow  <= overflow_n;
      wr        <= wr_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      run_ready <= run_ready_n;
      busy      <= busy_n;
      row_done  <= row_done_n;
    end
  end

endmodule

// File: tb/tb_pixbuf_run_writer.sv
// Bench for pixbuf_run_writer: a row-fill model predicts every pixel write,
// row_done and overflow; directed tests pin timing and corner cases.
module tb_pixbuf_run_writer;
  localparam int ROW_LEN = 640;

  logic        clk = 1'b0;
  logic        rst, row_start, run_valid, run_ready;
  logic [15:0] run_color;
  logic [9:0]  run_len;
  logic        wr, busy, row_done, overflow;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;

  pixbuf_run_writer #(.ADDR_W(10), .DATA_W(16), .LEN_W(10), .ROW_LEN(ROW_LEN)) dut (
    .clk(clk), .rst(rst), .row_start(row_start), .run_valid(run_valid),
    .run_ready(run_ready), .run_color(run_color), .run_len(run_len),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .row_done(row_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  m_pos, exp_done;
  bit  m_ovf;
  int  n_cmp, n_err;
  int  cyc, n_wr, n_done, done_cyc, last_addr;
  int  wcyc[0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Row model: pixels land at consecutive positions; past ROW_LEN they are dropped.
  task automatic model_accept(int color, int len);
    for (int i = 0; i < len; i++) begin
      if (m_pos < ROW_LEN) begin
        exp_q.push_back('{addr: m_pos, data: color});
        m_pos++;
      end else m_ovf = 1'b1;
    end
    if (len > 0 && m_pos == ROW_LEN) exp_done++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pos = 0; m_ovf = 1'b0; n_wr = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!wr) begin
        wr_t e;
        n_wr++; wcyc[wr_addr] = cyc; last_addr = wr_addr;
        chk("ready_low_in_write", run_ready, 0);
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
      if (row_done) begin
        n_done++; done_cyc = cyc;
        chk("row_done_expected", exp_done > 0, 1);
        chk("row_done_all_written", exp_q.size(), 0);
        chk("overflow_at_done", overflow, m_ovf);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_row_start();
    row_start = 1'b1; tick(); row_start = 1'b0;
    model_clear();
  endtask

  task automatic send_run(int color, int len);
    int n = 0;
    run_color = 16'(color); run_len = 10'(len); run_valid = 1'b1;
    while (!run_ready && n < 2000) begin tick(); n++; end
    chk("send_run_timeout", n < 2000, 1);
    if (n < 2000) model_accept(color, len);
    tick(); run_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
    chk("drain_timeout", n < 2000, 1);
    tick(); tick();
  endtask

  initial begin
    int n, d0;
    rst = 1'b1; row_start = 0; run_valid = 0; run_color = 0; run_len = 0;
    model_clear(); exp_done = 0;
    tick(); tick();
    chk("rst_wr", wr, 1);  chk("rst_addr", wr_addr, 0); chk("rst_data", wr_data, 0);
    chk("rst_ready", run_ready, 0); chk("rst_busy", busy, 0);
    chk("rst_done", row_done, 0);   chk("rst_ovf", overflow, 0);
    rst = 1'b0; tick();

    // 1: two half-row runs
    pulse_row_start();
    chk("t1_busy", busy, 1); chk("t1_ready", run_ready, 1);
    send_run(16'h0F00, 320);
    send_run(16'h00F0, 320);
    drain();
    chk("t1_writes", n_wr, 640);
    chk("t1_bubble", wcyc[320] - wcyc[319], 2);
    chk("t1_contig", wcyc[100] - wcyc[99], 1);
    chk("t1_done_lat", done_cyc - wcyc[639], 1);
    chk("t1_ovf", overflow, 0); chk("t1_idle_busy", busy, 0);
    chk("t1_idle_ready", run_ready, 0);

    // 2: zero-length run is swallowed
    pulse_row_start();
    send_run(16'h0FFF, 0);
    chk("t2_no_write", wr, 1);
    send_run(16'h000F, 5);
    drain();
    chk("t2_writes", n_wr, 5); chk("t2_last", last_addr, 4);

    // 3: overflow past end of row
    d0 = n_done;
    pulse_row_start();
    send_run(16'h0F00, 600);
    send_run(16'h00F0, 100);
    drain();
    chk("t3_writes", n_wr, 640); chk("t3_done", n_done - d0, 1);
    chk("t3_ovf", overflow, 1); chk("t3_busy", busy, 0);
    tick(); chk("t3_ovf_sticky", overflow, 1);

    // 4: abort at address 100
    d0 = n_done;
    pulse_row_start();
    chk("t4_ovf_cleared", overflow, 0);
    send_run(16'h0AAA, 300);
    n = 0;
    while (!(wr == 1'b0 && wr_addr == 10'd100) && n < 1000) begin tick(); n++; end
    chk("t4_reach_100", n < 1000, 1);
    row_start = 1'b1; tick(); row_start = 1'b0;
    model_clear();
    chk("t4_abort_wr", wr, 1); chk("t4_abort_ready", run_ready, 1);
    send_run(16'h0555, 10);
    chk("t4_restart_addr", wr_addr, 0); chk("t4_restart_wr", wr, 0);
    drain();
    chk("t4_no_done", n_done - d0, 0);

    // 5: reset in the middle of a run
    pulse_row_start();
    send_run(16'h0BBB, 50);
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    model_clear();
    chk("t5_wr", wr, 1); chk("t5_addr", wr_addr, 0); chk("t5_data", wr_data, 0);
    chk("t5_ready", run_ready, 0); chk("t5_busy", busy, 0);
    tick();
    chk("t5_idle_ready", run_ready, 0); chk("t5_idle_wr", wr, 1);

    // 6: held run_valid with a wandering color during WRITE
    pulse_row_start();
    run_color = 16'h0123; run_len = 10'd20; run_valid = 1'b1;
    n = 0;
    while (!run_ready && n < 100) begin tick(); n++; end
    chk("t6_accept", n < 100, 1);
    model_accept(16'h0123, 20);
    tick();
    for (int i = 0; i < 15; i++) begin
      run_color = 16'(i * 7 + 1); run_len = 10'd3;
      chk("t6_ready_low", run_ready, 0);
      chk("t6_data_latched", wr_data, 16'h0123);
      tick();
    end
    run_valid = 1'b0;
    drain();
    chk("t6_writes", n_wr, 20);

    chk("final_done_outstanding", exp_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
